led_display_phy: RTL and testbench

- Serialises one display row-pair (64 columns, top and bottom RGB) onto a HUB75-style LED matrix interface: bit clock, six colour lines, latch and 4-bit row address.
- Sits between the frame-RAM row fetcher (valid/ready row source) and the physical panel or the panel model.
- Accepts one 384-bit row per handshake, shifts 64 columns out, latches the row, then requests the next.

---
 rtl/led_display_phy_pkg.sv | 30 +++
 rtl/led_display_phy_bit_clk_gen.sv | 47 ++++
 rtl/led_display_phy.sv | 123 ++++++++++++
 tb/tb_led_display_phy.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_display_phy_pkg.sv
// rtl/led_display_phy_pkg.sv - shared types, sizes and pixel indexing for the LED display PHY
//
// Contents:
//   rgb_row_t          384-bit row-pair (64 columns x 6 colour bits)
//   NUM_COLS           columns per row
//   NUM_ROW_ADDR_BITS  width of the row-pair address
//   COL_BITS           width of a column index
//   phy_state_t        serialiser state encoding
//   pixel_lsb()        bit offset of a column's 6-bit pixel inside rgb_row_t
package led_display_package;

  typedef logic [383:0] rgb_row_t;

  localparam int NUM_COLS          = 64;
  localparam int NUM_ROW_ADDR_BITS = 4;
  localparam int COL_BITS          = 6;

  typedef enum logic [1:0] {
    ST_RESET,
    ST_IDLE,
    ST_SHIFT,
    ST_LATCH
  } phy_state_t;

  // Pixel c lives at row[6c+5:6c] = {b_bot, g_bot, r_bot, b_top, g_top, r_top}.
  function automatic logic [8:0] pixel_lsb(input logic [COL_BITS-1:0] col);
    return 9'(col) * 9'd6;
  endfunction

endpackage

// File: rtl/led_display_phy_bit_clk_gen.sv
// rtl/led_display_phy_bit_clk_gen.sv - divide-by-HALF strobe generator for the panel bit clock
//
// Ports:
//   clk    in   system clock
//   rst_n  in   asynchronous active-low reset
//   run    in   count while high; low clears the divider and the phase
//   rise   out  one-cycle strobe: end of a low half-period
//   fall   out  one-cycle strobe: end of a high half-period
//   level  out  current bit-clock phase (0 = low half, 1 = high half)
module bit_clk_gen #(
  parameter int HALF = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic rise,
  output logic fall,
  output logic level
);

  localparam int            CW   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [CW-1:0] LAST = CW'(HALF - 1);

  logic [CW-1:0] cnt;
  logic          tick;

  assign tick = run && (cnt == LAST);
  assign rise = tick && !level;
  assign fall = tick && level;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      level <= 1'b0;
    end else if (!run) begin
      // Restart aligned so the first half-period after run rises is a full HALF.
      cnt   <= '0;
      level <= 1'b0;
    end else if (tick) begin
      cnt   <= '0;
      level <= !level;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/led_display_phy.sv
// rtl/led_display_phy.sv - HUB75-style row-pair serialiser (shift 64 columns, then latch)
//
// Ports:
//   clk_in            in   system clock
//   n_reset_in        in   asynchronous active-low reset
//   row_in            in   row-pair pixel data (rgb_row_t)
//   row_valid_in      in   row_in / row_address_in valid
//   row_ready_out     out  idle, row can be accepted
//   row_address_in    in   row-pair address 0..15
//   bit_clk_out       out  panel shift clock (panel samples on rising edge)
//   red/green/blue_top_out, red/green/blue_bot_out  out  colour bits
//   latch_out         out  panel latch enable
//   address_out       out  panel row address (held between latches)
module led_display_phy
  import led_display_package::*;
#(
  parameter int SYS_CLK_FREQ = 100_000_000,
  parameter int BCLK_FREQ    = 21_000_000,
  parameter int NUM_COLS     = led_display_package::NUM_COLS
) (
  input  logic                         clk_in,
  input  logic                         n_reset_in,
  input  rgb_row_t                     row_in,
  input  logic                         row_valid_in,
  output logic                         row_ready_out,
  input  logic [NUM_ROW_ADDR_BITS-1:0] row_address_in,
  output logic                         bit_clk_out,
  output logic                         red_top_out,
  output logic                         green_top_out,
  output logic                         blue_top_out,
  output logic                         red_bot_out,
  output logic                         green_bot_out,
  output logic                         blue_bot_out,
  output logic                         latch_out,
  output logic [NUM_ROW_ADDR_BITS-1:0] address_out
);

  // Rounded up so the bit clock never exceeds BCLK_FREQ.
  localparam int HALF_RAW = (SYS_CLK_FREQ + 2 * BCLK_FREQ - 1) / (2 * BCLK_FREQ);
  localparam int HALF     = (HALF_RAW < 1) ? 1 : HALF_RAW;

  localparam logic [COL_BITS-1:0] COL_LAST = COL_BITS'(NUM_COLS - 1);

  phy_state_t                   state, state_d;
  rgb_row_t                     row_q;
  logic [NUM_ROW_ADDR_BITS-1:0] addr_q;
  logic [NUM_ROW_ADDR_BITS-1:0] address_q;
  logic [COL_BITS-1:0]          col;
  logic [1:0]                   step;
  logic                         capture;
  logic                         rise, fall, level;
  logic [5:0]                   pixel;

  bit_clk_gen #(.HALF(HALF)) u_bit_clk_gen (
    .clk   (clk_in),
    .rst_n (n_reset_in),
    .run   ((state == ST_SHIFT) || (state == ST_LATCH)),
    .rise  (rise),
    .fall  (fall),
    .level (level)
  );

  // LATCH is four HALF units: settle, latch high, latch high, settle.
  always_comb begin
    state_d = state;
    capture = 1'b0;
    unique case (state)
      ST_RESET: state_d = ST_IDLE;
      ST_IDLE: begin
        if (row_valid_in) begin
          state_d = ST_SHIFT;
          capture = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (fall && (col == '0)) state_d = ST_LATCH;
      end
      ST_LATCH: begin
        if ((rise || fall) && (step == 2'd3)) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge n_reset_in) begin
    if (!n_reset_in) begin
      state     <= ST_RESET;
      row_q     <= '0;
      addr_q    <= '0;
      address_q <= '0;
      col       <= '0;
      step      <= '0;
    end else begin
      state <= state_d;
      if (capture) begin
        row_q  <= row_in;
        addr_q <= row_address_in;
        col    <= COL_LAST;
      end
      // Column advances on the falling edge so data is stable across each rise.
      if ((state == ST_SHIFT) && fall && (col != '0)) col <= col - 1'b1;
      if ((state == ST_SHIFT) && (state_d == ST_LATCH)) begin
        address_q <= addr_q;
        step      <= '0;
      end
      if ((state == ST_LATCH) && (rise || fall)) step <= step + 1'b1;
    end
  end

  assign pixel = (state == ST_SHIFT) ? row_q[pixel_lsb(col) +: 6] : 6'b0;

  assign row_ready_out = (state == ST_IDLE);
  assign bit_clk_out   = (state == ST_SHIFT) && level;
  assign red_top_out   = pixel[0];
  assign green_top_out = pixel[1];
  assign blue_top_out  = pixel[2];
  assign red_bot_out   = pixel[3];
  assign green_bot_out = pixel[4];
  assign blue_bot_out  = pixel[5];
  assign latch_out     = (state == ST_LATCH) && ((step == 2'd1) || (step == 2'd2));
  assign address_out   = address_q;

endmodule

// File: tb/tb_led_display_phy.sv
// tb/tb_led_display_phy.sv - self-checking bench for led_display_phy with a shift/latch panel model
module tb_led_display_phy;
  import led_display_package::*;

  logic     clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  rgb_row_t   row_in;
  logic       row_valid;
  logic       row_ready;
  logic [3:0] row_addr;
  logic       bclk, rt, gt, bt, rb, gb, bb, latch;
  logic [3:0] addr_out;

  int checks   = 0;
  int failures = 0;

  led_display_phy dut (
    .clk_in         (clk),
    .n_reset_in     (rst_n),
    .row_in         (row_in),
    .row_valid_in   (row_valid),
    .row_ready_out  (row_ready),
    .row_address_in (row_addr),
    .bit_clk_out    (bclk),
    .red_top_out    (rt),
    .green_top_out  (gt),
    .blue_top_out   (bt),
    .red_bot_out    (rb),
    .green_bot_out  (gb),
    .blue_bot_out   (bb),
    .latch_out      (latch),
    .address_out    (addr_out)
  );

  // Panel model: shift on rising bit clock, store row at latch rise.
  rgb_row_t   model_sr;
  rgb_row_t   latched [16];
  int         latch_cnt = 0;
  logic [3:0] latch_addr;
  int         rise_idx = 0;
  logic [5:0] rise_col [64];
  wire  [5:0] colours = {bb, gb, rb, bt, gt, rt};

  always @(posedge bclk) begin
    model_sr = {model_sr[377:0], colours};
    if (rise_idx < 64) rise_col[rise_idx] = colours;
    rise_idx++;
  end

  always @(posedge latch) begin
    latched[addr_out] = model_sr;
    latch_addr = addr_out;
    latch_cnt++;
  end

  function automatic rgb_row_t rand_row();
    rgb_row_t r;
    for (int w = 0; w < 12; w++) r[w*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (row_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic send_row(input rgb_row_t r, input logic [3:0] a);
    bit ok;
    wait_ready(ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL send_ready: row_ready_out=%b required 1 within 1000 cycles", row_ready);
    end
    row_in    = r;
    row_addr  = a;
    row_valid = 1'b1;
    @(posedge clk);
    #1 row_valid = 1'b0;
  endtask

  task automatic wait_latch(input int target, input string name);
    for (int i = 0; i < 1000 && latch_cnt < target; i++) @(negedge clk);
    checks++;
    if (latch_cnt < target) begin
      failures++;
      $display("FAIL %s_latch_timeout: latch_count=%0d required %0d", name, latch_cnt, target);
    end
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    row_valid = 1'b1;
    row_in    = '1;
    row_addr  = 4'hf;
    repeat (3) @(negedge clk);
    checks++;
    if ({bclk, rt, gt, bt, rb, gb, bb, latch, addr_out, row_ready} !== 14'b0) begin
      failures++;
      $display("FAIL reset_outputs: got %b required all 0",
               {bclk, rt, gt, bt, rb, gb, bb, latch, addr_out, row_ready});
    end
    row_valid = 1'b0;
    row_in    = '0;
    row_addr  = '0;
    rst_n     = 1'b1;
    @(negedge clk);
    checks++;
    if (row_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready: row_ready_out=%b required 1", row_ready);
    end
  endtask

  task automatic test_single_row();
    rgb_row_t r;
    int       bad;
    int       base;
    bit       ok;
    r = '0;
    for (int c = 0; c < 64; c++) r[6*c] = 1'b1;
    rise_idx = 0;
    base = latch_cnt;
    send_row(r, 4'd5);
    wait_latch(base + 1, "single");
    wait_ready(ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL single_ready_return: row_ready_out=%b required 1", row_ready);
    end
    checks++;
    if (rise_idx != 64) begin
      failures++;
      $display("FAIL single_rise_count: rises=%0d required 64", rise_idx);
    end
    bad = 0;
    for (int i = 0; i < 64; i++) if (rise_col[i] !== 6'b000001) bad++;
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL single_colours: %0d rises not red_top only, required 0", bad);
    end
    checks++;
    if (latch_addr !== 4'd5) begin
      failures++;
      $display("FAIL single_address: address_out at latch=%0d required 5", latch_addr);
    end
    checks++;
    if (latched[5] !== r) begin
      failures++;
      $display("FAIL single_row_data: got %h required %h", latched[5], r);
    end
  endtask

  task automatic test_ordering();
    rgb_row_t r;
    int       bad;
    bit       ok;
    r = '0;
    r[5:0] = 6'h3f;
    rise_idx = 0;
    send_row(r, 4'd2);
    wait_ready(ok);
    checks++;
    if (rise_idx != 64) begin
      failures++;
      $display("FAIL order_rise_count: rises=%0d required 64", rise_idx);
    end
    checks++;
    if (rise_col[63] !== 6'h3f) begin
      failures++;
      $display("FAIL order_last_col: colours on rise 64=%b required 111111", rise_col[63]);
    end
    bad = 0;
    for (int i = 0; i < 63; i++) if (rise_col[i] !== 6'h00) bad++;
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL order_early_cols: %0d early rises non-zero, required 0", bad);
    end
  endtask

  task automatic test_timing();
    logic prev;
    int   run, highs, bad_hi, bad_lo, lat_hi, lat_shift, ready_at, latch_first;
    prev = 1'b0; run = 0; highs = 0; bad_hi = 0; bad_lo = 0;
    lat_hi = 0; lat_shift = 0; ready_at = -1; latch_first = -1;
    send_row(rand_row(), 4'd7);
    for (int i = 1; i <= 400; i++) begin
      @(negedge clk);
      if (bclk !== prev) begin
        if (bclk === 1'b1) begin
          if (run != 3) bad_lo++;
        end else begin
          if (run != 3) bad_hi++;
          highs++;
        end
        run  = 1;
        prev = bclk;
      end else begin
        run++;
      end
      if (latch === 1'b1) begin
        lat_hi++;
        if (latch_first < 0) latch_first = i;
        if (highs < 64) lat_shift++;
      end
      if (row_ready === 1'b1 && ready_at < 0) ready_at = i;
    end
    checks++;
    if (highs != 64) begin
      failures++;
      $display("FAIL timing_periods: high phases=%0d required 64", highs);
    end
    checks++;
    if (bad_hi != 0) begin
      failures++;
      $display("FAIL timing_high_len: %0d high phases not 3 clocks, required 0", bad_hi);
    end
    checks++;
    if (bad_lo != 0) begin
      failures++;
      $display("FAIL timing_low_len: %0d low phases not 3 clocks, required 0", bad_lo);
    end
    checks++;
    if (lat_hi != 6) begin
      failures++;
      $display("FAIL timing_latch_len: latch high clocks=%0d required 6", lat_hi);
    end
    checks++;
    if (lat_shift != 0) begin
      failures++;
      $display("FAIL timing_latch_in_shift: latch high during shift=%0d required 0", lat_shift);
    end
    checks++;
    if (latch_first != 388) begin
      failures++;
      $display("FAIL timing_latch_start: first latch clock=%0d required 388", latch_first);
    end
    checks++;
    if (ready_at != 397) begin
      failures++;
      $display("FAIL timing_ready_return: ready at clock=%0d required 397", ready_at);
    end
  endtask

  task automatic test_frame();
    rgb_row_t stim [16];
    int       base;
    bit       ok;
    for (int a = 0; a < 16; a++) begin
      stim[a]    = rand_row();
      latched[a] = 'x;
    end
    base = latch_cnt;
    for (int a = 0; a < 16; a++) send_row(stim[a], 4'(a));
    wait_latch(base + 16, "frame");
    wait_ready(ok);
    for (int a = 0; a < 16; a++) begin
      checks++;
      if (latched[a] !== stim[a]) begin
        failures++;
        $display("FAIL frame_row%0d: got %h required %h", a, latched[a], stim[a]);
      end
    end
  endtask

  task automatic test_back_to_back();
    rgb_row_t ra, rb_row;
    int       base, ready_hi;
    bit       ok;
    ra       = rand_row();
    rb_row   = rand_row();
    latched[3] = 'x;
    latched[9] = 'x;
    base     = latch_cnt;
    ready_hi = 0;
    send_row(ra, 4'd3);
    row_in    = rb_row;
    row_addr  = 4'd9;
    row_valid = 1'b1;
    for (int i = 0; i < 1000 && latch_cnt < base + 1; i++) begin
      @(negedge clk);
      if (row_ready === 1'b1) ready_hi++;
    end
    checks++;
    if (ready_hi != 0) begin
      failures++;
      $display("FAIL hs_ready_during_shift: ready high clocks=%0d required 0", ready_hi);
    end
    checks++;
    if (latched[3] !== ra) begin
      failures++;
      $display("FAIL hs_inflight_row: got %h required %h", latched[3], ra);
    end
    wait_ready(ok);
    @(posedge clk);
    #1 row_valid = 1'b0;
    wait_latch(base + 2, "hs_second");
    checks++;
    if (latched[9] !== rb_row) begin
      failures++;
      $display("FAIL hs_next_row: got %h required %h", latched[9], rb_row);
    end
    checks++;
    if (latch_addr !== 4'd9) begin
      failures++;
      $display("FAIL hs_next_addr: address_out at latch=%0d required 9", latch_addr);
    end
    wait_ready(ok);
  endtask

  task automatic test_reset_mid_shift();
    int base;
    send_row(rand_row(), 4'd11);
    base = latch_cnt;
    repeat (100) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bclk, rt, gt, bt, rb, gb, bb, latch, addr_out, row_ready} !== 14'b0) begin
      failures++;
      $display("FAIL midreset_outputs: got %b required all 0",
               {bclk, rt, gt, bt, rb, gb, bb, latch, addr_out, row_ready});
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (500) @(negedge clk);
    checks++;
    if (latch_cnt != base) begin
      failures++;
      $display("FAIL midreset_no_latch: latches=%0d required %0d", latch_cnt, base);
    end
    checks++;
    if (row_ready !== 1'b1) begin
      failures++;
      $display("FAIL midreset_ready: row_ready_out=%b required 1", row_ready);
    end
  endtask

  initial begin
    row_valid = 1'b0;
    row_in    = '0;
    row_addr  = '0;
    test_reset();
    test_single_row();
    test_ordering();
    test_timing();
    test_frame();
    test_back_to_back();
    test_reset_mid_shift();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
